// File: rtl/niossoc_nios2cpu_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II A-stage (div/divu).
// Produces quotient and remainder, signed or unsigned, one quotient bit per clock.
// Optional macro NIOS_DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module niossoc_nios2cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    input  logic             A_div_signed,
    input  logic             A_div_start,
    output logic             A_div_busy,
    output logic             A_div_done,
    output logic [WIDTH-1:0] A_div_quot,
    output logic [WIDTH-1:0] A_div_rem
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_N = CNT_W'(WIDTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] prem;   // partial remainder
    logic [WIDTH-1:0] dvd;    // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr;    // divisor magnitude
    logic             qsign;
    logic             rsign;
    logic             dzero;

    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1), still representable.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        if (is_signed && (sv < 0))
            return ~v + ONE;
        return v;
    endfunction

    // Two's-complement negate when requested.
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    // Trial subtract over WIDTH+1 bits. Because prem < dsr is kept as an invariant,
    // shifted < 2*dsr, so the MSB of the difference is a reliable sign bit.
    // With a zero divisor the quotient bits may come out wrong, but the quotient is
    // overridden in FIXUP and prem still ends up holding the dividend magnitude.
    always_comb begin
        mag1     = magnitude(A_div_src1, A_div_signed);
        mag2     = magnitude(A_div_src2, A_div_signed);
        shifted  = {prem, dvd[WIDTH-1]};
        trial    = shifted - {1'b0, dsr};
        trial_ok = ~trial[WIDTH];
    end

    // Sequencer and datapath: accept, WIDTH iterations, sign fixup, done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            count      <= '0;
            prem       <= '0;
            dvd        <= '0;
            dsr        <= '0;
            qsign      <= 1'b0;
            rsign      <= 1'b0;
            dzero      <= 1'b0;
            A_div_quot <= '0;
            A_div_rem  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (A_div_start) begin
                        dvd   <= mag1;
                        dsr   <= mag2;
                        qsign <= A_div_signed & (A_div_src1[WIDTH-1] ^ A_div_src2[WIDTH-1]);
                        rsign <= A_div_signed & A_div_src1[WIDTH-1];
                        dzero <= (A_div_src2 == '0);
                        count <= CNT_N;
`ifdef NIOS_DIV_ZERO_FAST_EN
                        if (A_div_src2 == '0) begin
                            // Remainder is the dividend; load its magnitude directly.
                            prem  <= mag1;
                            state <= S_FIXUP;
                        end else begin
                            prem  <= '0;
                            state <= S_RUN;
                        end
`else
                        prem  <= '0;
                        state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    prem  <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], trial_ok};
                    count <= count - CNT_1;
                    if (count == CNT_1)
                        state <= S_FIXUP;
                end
                S_FIXUP: begin
                    A_div_quot <= dzero ? '1 : cond_negate(dvd, qsign);
                    A_div_rem  <= cond_negate(prem, rsign);
                    state      <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status decode straight from state so reset clears it immediately.
    always_comb begin
        A_div_busy = (state == S_RUN) || (state == S_FIXUP);
        A_div_done = (state == S_DONE);
    end

endmodule

// File: tb/tb_niossoc_nios2cpu_div_cell.sv
// Self-checking bench for niossoc_nios2cpu_div_cell (WIDTH=32).
// Honours NIOS_DIV_ZERO_FAST_EN for zero-divisor latency expectations.
module tb_niossoc_nios2cpu_div_cell;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] src1, src2;
    logic         sgn, start;
    logic         busy, done;
    logic [W-1:0] quot, rem;

    niossoc_nios2cpu_div_cell #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .A_div_src1(src1), .A_div_src2(src2),
        .A_div_signed(sgn), .A_div_start(start),
        .A_div_busy(busy), .A_div_done(done),
        .A_div_quot(quot), .A_div_rem(rem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   bfrom = 1;
    int   bto = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero rule.
    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint q, r;
        longint unsigned uq, ur;
        logic [63:0] res;
        if (b == 0) begin
            res = {32'hFFFF_FFFF, a};
        end else if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            res = {q[31:0], r[31:0]};
        end else begin
            uq = longint'(a) / longint'(b);
            ur = longint'(a) % longint'(b);
            res = {uq[31:0], ur[31:0]};
        end
        return res;
    endfunction

    function automatic int lat_of(input logic [W-1:0] b);
`ifdef NIOS_DIV_ZERO_FAST_EN
        return (b == 0) ? 2 : W + 2;
`else
        return W + 2;
`endif
    endfunction

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    // Called at a negedge; drives a one-cycle start and returns one negedge later.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
        logic [63:0] m;
        exp_t e;
        src1 = a; src2 = b; sgn = s; start = 1'b1;
        if (push) begin
            m = model(a, b, s);
            e.q = m[63:32]; e.r = m[31:0]; e.cyc = cyc + lat_of(b);
            sb.push_back(e);
            bfrom = cyc + 1;
            bto   = cyc + lat_of(b) - 1;
        end
        @(negedge clk);
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; sgn = 1'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue and wait until the earliest cycle a new start may be accepted.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        issue(a, b, s, 1'b1);
        wait_cycles(lat_of(b));
    endtask

    // Monitor: busy every cycle, result and timing whenever done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            check("busy", {63'd0, busy}, {63'd0, (cyc >= bfrom && cyc <= bto)});
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1 expected no result pending", cyc);
                end else begin
                    e = sb.pop_front();
                    check("quot", {32'd0, quot}, {32'd0, e.q});
                    check("rem", {32'd0, rem}, {32'd0, e.r});
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        reset_n = 1'b0; start = 1'b0; src1 = '0; src2 = '0; sgn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_quot", {32'd0, quot}, 64'd0);
        check("rst_rem", {32'd0, rem}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run(32'd100, 32'd7, 1'b0);
        run(-32'sd100, 32'd7, 1'b1);
        run(32'd100, -32'sd7, 1'b1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(32'hFFFF_FFFF, 32'd1, 1'b0);
        run(32'h1234_5678, 32'd0, 1'b0);
        run(32'h1234_5678, 32'd0, 1'b1);
        run(32'h8765_4321, 32'd0, 1'b1);

        // Start while busy is ignored; second op accepted at cycle 35
        issue(32'd50, 32'd5, 1'b0, 1'b1);
        wait_cycles(9);
        issue(32'd9, 32'd3, 1'b0, 1'b0);
        wait_cycles(24);
        run(32'd9, 32'd3, 1'b0);

        // Start during the DONE cycle is ignored
        issue(32'd77, 32'd4, 1'b0, 1'b1);
        wait_cycles(W + 1);
        issue(32'd1, 32'd1, 1'b0, 1'b0);
        run(32'd81, 32'd9, 1'b1);

        // Reset mid-RUN aborts without a done pulse
        issue(32'd1000, 32'd3, 1'b0, 1'b1);
        wait_cycles(14);
        #2;
        reset_n = 1'b0;
        sb.delete();
        bfrom = 1; bto = -1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_quot", {32'd0, quot}, 64'd0);
        check("abort_rem", {32'd0, rem}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        run(32'd8, 32'd2, 1'b0);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            run(rnd(), rnd(), 1'($urandom));
        end

        c = 0;
        while (sb.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
